// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage and decode: bubble/halt words, RV32 opcodes, run states.
package instruction_fetch_pkg;

   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
   localparam logic [31:0] HALT_INSN = 32'h0000_0073;

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } if_state_e;

   function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
      return insn[6:0];
   endfunction

endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// Instruction memory: synchronous write port, registered read port with read enable, no reset.
module instruction_fetch_instr_mem #(
   parameter int unsigned Depth = 64,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem [Depth];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, run-control FSM and IFID output registers in front of decode.
module instruction_fetch #(
   parameter int unsigned     PC_W       = 8,
   parameter int unsigned     IMEM_DEPTH = 64,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter logic [31:0]     NOP_INSN   = instruction_fetch_pkg::NOP_INSN,
   parameter logic [31:0]     HALT_INSN  = instruction_fetch_pkg::HALT_INSN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            imem_we,
   input  logic [PC_W-3:0] imem_waddr,
   input  logic [31:0]     imem_wdata,
   output logic [31:0]     IFID,
   output logic [PC_W-1:0] IFID_PC,
   output logic [PC_W-1:0] pc,
   output logic            halted
);

   import instruction_fetch_pkg::*;

   if_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [31:0]     rdata;
   logic            halt_hit;
   logic            fetch;

   // The fetched word lives in the memory's read register; ifid_valid_q selects it over the bubble.
   // A halt word there means the FSM is logically in HALT already; the state flop catches up next edge.
   assign halt_hit = (state_q == StRun) && ifid_valid_q && (rdata == HALT_INSN);
   assign fetch    = (state_q == StRun) && !halt_hit && !branch_taken && !stall;

   instruction_fetch_instr_mem #(
      .Depth (IMEM_DEPTH),
      .AddrW (PC_W - 2)
   ) u_instr_mem (
      .clk_i   (clk),
      .we_i    (imem_we && (state_q == StIdle)),
      .waddr_i (imem_waddr),
      .wdata_i (imem_wdata),
      .re_i    (fetch),
      .raddr_i (pc_q[PC_W-1:2]),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (halt_hit) begin
               state_d      = StHalt;
               ifid_valid_d = 1'b0;
            end else if (branch_taken) begin
               pc_d         = branch_target & ~PC_W'(3);
               ifid_pc_d    = '0;
               ifid_valid_d = 1'b0;
            end else if (!stall) begin
               pc_d         = pc_q + PC_W'(4);
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b1;
            end
         end
         StHalt: begin
            ifid_valid_d = 1'b0;
         end
         default: begin
            state_d      = StIdle;
            ifid_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign IFID    = ifid_valid_q ? rdata : NOP_INSN;
   assign IFID_PC = ifid_pc_q;
   assign pc      = pc_q;
   assign halted  = (state_q == StHalt) || halt_hit;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against a cycle-level behavioural model.
module tb_instruction_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'h0000_0073;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = '0;
   logic        imem_we = 1'b0;
   logic [5:0]  imem_waddr = '0;
   logic [31:0] imem_wdata = '0;
   logic [31:0] IFID;
   logic [7:0]  IFID_PC;
   logic [7:0]  pc;
   logic        halted;

   int n_cmp = 0;
   int n_fail = 0;

   // Model state: mode 0 idle, 1 run, 2 halt.
   int          m_mode;
   logic [7:0]  m_pc;
   logic [7:0]  m_ifid_pc;
   logic [31:0] m_ifid;
   logic [31:0] m_mem [64];

   logic [31:0] prog [4] = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3, 32'h0000_0073};

   instruction_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_we       (imem_we),
      .imem_waddr    (imem_waddr),
      .imem_wdata    (imem_wdata),
      .IFID          (IFID),
      .IFID_PC       (IFID_PC),
      .pc            (pc),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode    = 0;
      m_pc      = 8'h00;
      m_ifid_pc = 8'h00;
      m_ifid    = NOP;
   endtask

   task automatic model_step(input logic st, input logic sl, input logic bt, input logic [7:0] tgt,
                             input logic we, input logic [5:0] wa, input logic [31:0] wd);
      logic [31:0] w;
      if (m_mode == 0) begin
         if (we) m_mem[wa] = wd;
         if (st) m_mode = 1;
      end else if (m_mode == 1) begin
         if (bt) begin
            m_pc      = {tgt[7:2], 2'b00};
            m_ifid    = NOP;
            m_ifid_pc = 8'h00;
         end else if (!sl) begin
            w         = m_mem[m_pc[7:2]];
            m_ifid    = w;
            m_ifid_pc = m_pc;
            m_pc      = m_pc + 8'd4;
            if (w == HALT) m_mode = 2;
         end
      end else begin
         m_ifid = NOP;
      end
   endtask

   task automatic cycle(input logic st, input logic sl, input logic bt, input logic [7:0] tgt,
                        input logic we, input logic [5:0] wa, input logic [31:0] wd);
      start = st; stall = sl; branch_taken = bt; branch_target = tgt;
      imem_we = we; imem_waddr = wa; imem_wdata = wd;
      model_step(st, sl, bt, tgt, we, wa, wd);
      @(posedge clk); #1;
      start = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_we = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      model_reset();
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      n_cmp++; if (IFID !== NOP) begin n_fail++; $display("FAIL reset_ifid got %h want %h", IFID, NOP); end
      n_cmp++; if (IFID_PC !== 8'h00) begin n_fail++; $display("FAIL reset_ifid_pc got %h want 00", IFID_PC); end
      n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
      n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_and_run();
      logic [31:0] w;
      logic [7:0]  exp_pc [4] = '{8'h00, 8'h04, 8'h08, 8'h0c};
      for (int i = 0; i < 64; i++) begin
         w = (i < 4) ? prog[i] : $urandom();
         if (i >= 4 && w == HALT) w = NOP;
         cycle(1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 6'(i), w);
      end
      n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL idle_pc got %h want 00", pc); end
      n_cmp++; if (IFID !== NOP) begin n_fail++; $display("FAIL idle_ifid got %h want %h", IFID, NOP); end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
         n_cmp++;
         if (IFID !== prog[i] || IFID_PC !== exp_pc[i]) begin
            n_fail++;
            $display("FAIL run[%0d] got %h@%h want %h@%h", i, IFID, IFID_PC, prog[i], exp_pc[i]);
         end
      end
      n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_edge got %b want 1", halted); end
      cycle(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 6'd0, 32'h0);
      n_cmp++;
      if (IFID !== NOP || halted !== 1'b1 || pc !== 8'h10) begin
         n_fail++;
         $display("FAIL halt_state got ifid=%h h=%b pc=%h want %h 1 10", IFID, halted, pc, NOP);
      end
      idle_n(2);
      n_cmp++; if (pc !== 8'h10) begin n_fail++; $display("FAIL halt_frozen_pc got %h want 10", pc); end
   endtask

   task automatic test_stall();
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      idle_n(2);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
         n_cmp++;
         if (IFID !== 32'h00a0_0113 || pc !== 8'h08 || IFID_PC !== 8'h04) begin
            n_fail++;
            $display("FAIL stall[%0d] got %h@%h pc=%h want 00a00113@04 pc=08", i, IFID, IFID_PC, pc);
         end
      end
      idle_n(1);
      n_cmp++;
      if (IFID_PC !== 8'h08 || IFID !== 32'h0020_81b3) begin
         n_fail++; $display("FAIL unstall got %h@%h want 002081b3@08", IFID, IFID_PC);
      end
   endtask

   task automatic test_redirect(input logic with_stall, input logic [7:0] tgt);
      logic [7:0] al;
      al = {tgt[7:2], 2'b00};
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      idle_n(2);
      cycle(1'b0, with_stall, 1'b1, tgt, 1'b0, 6'd0, 32'h0);
      n_cmp++;
      if (IFID !== NOP || IFID_PC !== 8'h00 || pc !== al) begin
         n_fail++;
         $display("FAIL redirect(st=%b) got %h@%h pc=%h want %h@00 pc=%h",
                  with_stall, IFID, IFID_PC, pc, NOP, al);
      end
      idle_n(1);
      n_cmp++;
      if (IFID !== m_mem[al[7:2]] || IFID_PC !== al) begin
         n_fail++;
         $display("FAIL redirect_next got %h@%h want %h@%h", IFID, IFID_PC, m_mem[al[7:2]], al);
      end
   endtask

   task automatic test_redirect_over_halt();
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      idle_n(3);
      cycle(1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 6'd0, 32'h0);
      n_cmp++;
      if (halted !== 1'b0 || pc !== 8'h30 || IFID !== NOP) begin
         n_fail++; $display("FAIL redirect_over_halt got h=%b pc=%h ifid=%h want 0 30 %h", halted, pc, IFID, NOP);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] seq [4] = '{8'hf8, 8'hfc, 8'h00, 8'h04};
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 8'hf8, 1'b0, 6'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
         n_cmp++;
         if (IFID_PC !== seq[i] || IFID !== m_mem[seq[i][7:2]]) begin
            n_fail++;
            $display("FAIL wrap[%0d] got %h@%h want %h@%h", i, IFID, IFID_PC, m_mem[seq[i][7:2]], seq[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'd1, 32'hdead_beef);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'd1, 32'hdead_beef);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (IFID !== NOP || IFID_PC !== 8'h00 || pc !== 8'h00 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got %h@%h pc=%h h=%b want %h@00 pc=00 h=0", IFID, IFID_PC, pc, halted, NOP);
      end
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      idle_n(2);
      n_cmp++;
      if (IFID !== 32'h00a0_0113 || IFID_PC !== 8'h04) begin
         n_fail++; $display("FAIL mem_persist got %h@%h want 00a00113@04", IFID, IFID_PC);
      end
   endtask

   task automatic test_random();
      logic st, sl, bt, we;
      logic [31:0] wd;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         st = ($urandom_range(0, 7) == 0);
         sl = ($urandom_range(0, 3) == 0);
         bt = ($urandom_range(0, 7) == 0);
         we = ($urandom_range(0, 1) == 1);
         wd = ($urandom_range(0, 9) == 0) ? HALT : $urandom();
         cycle(st, sl, bt, 8'($urandom()), we, 6'($urandom()), wd);
         n_cmp++;
         if (IFID !== m_ifid || pc !== m_pc || halted !== (m_mode == 2) ||
             (m_mode != 2 && IFID_PC !== m_ifid_pc)) begin
            n_fail++;
            $display("FAIL rand[%0d] got %h@%h pc=%h h=%b want %h@%h pc=%h h=%b", i, IFID, IFID_PC,
                     pc, halted, m_ifid, m_ifid_pc, m_pc, (m_mode == 2));
         end
         if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_and_run();
      test_stall();
      test_redirect(1'b0, 8'h22);
      test_redirect(1'b1, 8'h47);
      test_redirect_over_halt();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
